awg_sweep_ctrl: RTL



---
 rtl/awg_pkg.sv | 27 ++
 rtl/awg_sweep_next.sv | 65 ++++++
 rtl/awg_sweep_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/awg_pkg.sv
// Shared definitions for the DDS sweep sequencer: register map, MODE bits,
// sequencer state encoding and the widths shared with the sine generator.
package awg_pkg;

    localparam int GEN_FW  = 12;
    localparam int GEN_AW  = 3;
    localparam int GEN_PW  = 8;
    localparam int DWELL_W = 16;

    localparam logic [2:0] ADDR_F_START = 3'd0;
    localparam logic [2:0] ADDR_F_STOP  = 3'd1;
    localparam logic [2:0] ADDR_F_STEP  = 3'd2;
    localparam logic [2:0] ADDR_DWELL   = 3'd3;
    localparam logic [2:0] ADDR_AMP_PH  = 3'd4;
    localparam logic [2:0] ADDR_MODE    = 3'd5;

    localparam int MODE_REPEAT = 0;
    localparam int MODE_TRI    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/awg_sweep_next.sv
// Combinational next-frequency calculator: picks the following sweep value,
// the direction to use with it, or flags that the sweep has ended.
module awg_sweep_next
    import awg_pkg::*;
#(
    parameter int FW = GEN_FW
) (
    input  logic [FW-1:0] freq_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic          dir_down_i,
    input  logic          repeat_i,
    input  logic          tri_mode_i,
    output logic [FW-1:0] freq_o,
    output logic          dir_down_o,
    output logic          end_o
);

    logic [FW:0] up_sum;
    logic [FW:0] dn_diff;
    logic        up_ok;
    logic        dn_ok;

    // One extra bit catches carry past the top and borrow below zero.
    always_comb begin
        up_sum  = {1'b0, freq_i} + {1'b0, f_step_i};
        dn_diff = {1'b0, freq_i} - {1'b0, f_step_i};
        up_ok   = (up_sum <= {1'b0, f_stop_i});
        dn_ok   = !dn_diff[FW] && (dn_diff[FW-1:0] >= f_start_i);
    end

    always_comb begin
        freq_o     = freq_i;
        dir_down_o = dir_down_i;
        end_o      = 1'b0;
        if (!dir_down_i) begin
            if (up_ok) begin
                freq_o = up_sum[FW-1:0];
            end else if (tri_mode_i && dn_ok) begin
                freq_o     = dn_diff[FW-1:0];
                dir_down_o = 1'b1;
            end else if (repeat_i) begin
                freq_o     = f_start_i;
                dir_down_o = 1'b0;
            end else begin
                end_o = 1'b1;
            end
        end else begin
            if (dn_ok) begin
                freq_o = dn_diff[FW-1:0];
            end else if (repeat_i && up_ok) begin
                freq_o     = up_sum[FW-1:0];
                dir_down_o = 1'b0;
            end else if (repeat_i) begin
                // A failed turn falls back to a fresh pass from the start value.
                freq_o     = f_start_i;
                dir_down_o = 1'b0;
            end else begin
                end_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Sweep sequencer for the DDS sine generator: shadow config registers, a
// validity-checked start, and a dwell/step FSM with registered outputs.
module awg_sweep_ctrl
    import awg_pkg::*;
#(
    parameter int FW = GEN_FW,
    parameter int AW = GEN_AW,
    parameter int PW = GEN_PW,
    parameter int DW = DWELL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [15:0]   cfg_data,
    input  logic          start,
    input  logic          abort,
    output logic          gen_en,
    output logic [FW-1:0] gen_freq,
    output logic [AW-1:0] gen_amp,
    output logic [PW-1:0] gen_phase,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    logic [FW-1:0] sh_start_q, sh_stop_q, sh_step_q;
    logic [DW-1:0] sh_dwell_q;
    logic [AW-1:0] sh_amp_q;
    logic [PW-1:0] sh_phase_q;
    logic [1:0]    sh_mode_q;

    logic [FW-1:0] act_start_q, act_stop_q, act_step_q;
    logic [DW-1:0] act_dwell_q;
    logic [1:0]    act_mode_q;

    state_e        state_q;
    logic          dir_down_q;
    logic [DW-1:0] cnt_q;
    logic          gen_en_q, busy_q, done_q, cfg_err_q;
    logic [FW-1:0] gen_freq_q;
    logic [AW-1:0] gen_amp_q;
    logic [PW-1:0] gen_phase_q;

    logic [FW-1:0] nxt_freq_d;
    logic          nxt_dir_d;
    logic          nxt_end_d;
    logic          cfg_ok_d;

    function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - DW'(1);
    endfunction

    always_comb begin
        cfg_ok_d = (sh_step_q != '0) && (sh_start_q <= sh_stop_q) && (sh_amp_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_step_q  <= '0;
            sh_dwell_q <= DW'(1);
            sh_amp_q   <= AW'(1);
            sh_phase_q <= '0;
            sh_mode_q  <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_F_START: sh_start_q <= cfg_data[FW-1:0];
                ADDR_F_STOP:  sh_stop_q  <= cfg_data[FW-1:0];
                ADDR_F_STEP:  sh_step_q  <= cfg_data[FW-1:0];
                ADDR_DWELL:   sh_dwell_q <= cfg_data[DW-1:0];
                ADDR_AMP_PH: begin
                    sh_amp_q   <= cfg_data[AW-1:0];
                    sh_phase_q <= cfg_data[8 +: PW];
                end
                ADDR_MODE:    sh_mode_q  <= cfg_data[1:0];
                default: ;
            endcase
        end
    end

    awg_sweep_next #(.FW(FW)) u_next (
        .freq_i     (gen_freq_q),
        .f_start_i  (act_start_q),
        .f_stop_i   (act_stop_q),
        .f_step_i   (act_step_q),
        .dir_down_i (dir_down_q),
        .repeat_i   (act_mode_q[MODE_REPEAT]),
        .tri_mode_i (act_mode_q[MODE_TRI]),
        .freq_o     (nxt_freq_d),
        .dir_down_o (nxt_dir_d),
        .end_o      (nxt_end_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_down_q  <= 1'b0;
            cnt_q       <= '0;
            act_start_q <= '0;
            act_stop_q  <= '0;
            act_step_q  <= '0;
            act_dwell_q <= DW'(1);
            act_mode_q  <= '0;
            gen_en_q    <= 1'b0;
            gen_freq_q  <= '0;
            gen_amp_q   <= AW'(1);
            gen_phase_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (abort) begin
                state_q    <= ST_IDLE;
                gen_en_q   <= 1'b0;
                gen_freq_q <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && cfg_ok_d) begin
                            act_start_q <= sh_start_q;
                            act_stop_q  <= sh_stop_q;
                            act_step_q  <= sh_step_q;
                            act_dwell_q <= sh_dwell_q;
                            act_mode_q  <= sh_mode_q;
                            gen_en_q    <= 1'b1;
                            gen_freq_q  <= sh_start_q;
                            gen_amp_q   <= sh_amp_q;
                            gen_phase_q <= sh_phase_q;
                            busy_q      <= 1'b1;
                            dir_down_q  <= 1'b0;
                            cnt_q       <= dwell_load(sh_dwell_q);
                            state_q     <= ST_DWELL;
                        end else if (start) begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    // The step happens on the last dwell cycle, so frequencies abut.
                    ST_DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DW'(1);
                        end else if (nxt_end_d) begin
                            state_q    <= ST_DONE;
                            gen_en_q   <= 1'b0;
                            gen_freq_q <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            gen_freq_q <= nxt_freq_d;
                            dir_down_q <= nxt_dir_d;
                            cnt_q      <= dwell_load(act_dwell_q);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        gen_en_q   <= 1'b0;
                        gen_freq_q <= '0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gen_en    = gen_en_q;
    assign gen_freq  = gen_freq_q;
    assign gen_amp   = gen_amp_q;
    assign gen_phase = gen_phase_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
